// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcodes, state encoding and latency classes for the FPU issue controller.
// No ports; imported by fpu_lat_lookup and fpu_issue_ctrl.
package fpu_pkg;

    localparam logic [4:0] FADD  = 5'b00000;
    localparam logic [4:0] FSUB  = 5'b00001;
    localparam logic [4:0] FMUL  = 5'b00010;
    localparam logic [4:0] FDIV  = 5'b00011;
    localparam logic [4:0] FSQRT = 5'b01011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CLS_ADD,
        CLS_MUL,
        CLS_DIV,
        CLS_SQRT,
        CLS_MISC
    } lat_cls_e;

    function automatic lat_cls_e lat_class(input logic [4:0] f5);
        return (f5 == FADD || f5 == FSUB) ? CLS_ADD :
               (f5 == FMUL)  ? CLS_MUL  :
               (f5 == FDIV)  ? CLS_DIV  :
               (f5 == FSQRT) ? CLS_SQRT : CLS_MISC;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: EX-stage decode, FPU start/select and FP writeback signals.
// master = pipeline side (drives ex_*, flush, wb_ready); slave = fpu_issue_ctrl.
interface fpu_issue_ctrl_if;

    logic       ex_fp_valid;
    logic [4:0] ex_funct5;
    logic [2:0] ex_rm;
    logic [4:0] ex_rd;
    logic       ex_fp_we;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       ex_rs1_fp;
    logic       ex_rs2_fp;
    logic       flush;
    logic       stall;
    logic       fpu_start;
    logic [4:0] fpu_sel;
    logic [2:0] fpu_rm;
    logic       wb_valid;
    logic       wb_ready;
    logic [4:0] wb_rd;
    logic       wb_fp_we;

    modport master (
        output ex_fp_valid, ex_funct5, ex_rm, ex_rd, ex_fp_we,
               ex_rs1, ex_rs2, ex_rs1_fp, ex_rs2_fp, flush, wb_ready,
        input  stall, fpu_start, fpu_sel, fpu_rm, wb_valid, wb_rd, wb_fp_we
    );

    modport slave (
        input  ex_fp_valid, ex_funct5, ex_rm, ex_rd, ex_fp_we,
               ex_rs1, ex_rs2, ex_rs1_fp, ex_rs2_fp, flush, wb_ready,
        output stall, fpu_start, fpu_sel, fpu_rm, wb_valid, wb_rd, wb_fp_we
    );

endinterface

// File: rtl/fpu_lat_lookup.sv
// fpu_lat_lookup: combinational funct5 -> latency (in cycles) mapping.
// Ports: funct5 (in, 5) operation code; lat (out, CNT_W) latency of that op class.
module fpu_lat_lookup
    import fpu_pkg::*;
#(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 16,
    parameter int LAT_MISC = 1,
    parameter int CNT_W    = 5
) (
    input  logic [4:0]       funct5,
    output logic [CNT_W-1:0] lat
);

    lat_cls_e cls;

    always_comb begin
        cls = lat_class(funct5);
        lat = cls == CLS_ADD  ? CNT_W'(LAT_ADD)  :
              cls == CLS_MUL  ? CNT_W'(LAT_MUL)  :
              cls == CLS_DIV  ? CNT_W'(LAT_DIV)  :
              cls == CLS_SQRT ? CNT_W'(LAT_SQRT) : CNT_W'(LAT_MISC);
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/writeback controller for the multi-cycle non-pipelined FPU.
// Ports: clk, rst_n (async active-low); bus (fpu_issue_ctrl_if.slave) carrying EX decode,
// flush, stall, FPU start/sel/rm and the wb valid/ready port; stall_cycles (out, 32)
// stall performance counter, live only when FPU_STALL_CNT_EN is defined, else tied to 0.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 16,
    parameter int LAT_MISC = 1,
    parameter int CNT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_issue_ctrl_if.slave      bus,
    output logic [31:0]          stall_cycles
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat;
    logic [4:0]       rd_q;
    logic             fp_we_q;
    logic             pending;
    logic             complete;
    logic             raw;
    logic             struct_hz;
    logic             accept;

    fpu_lat_lookup #(
        .LAT_ADD (LAT_ADD),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV),
        .LAT_SQRT(LAT_SQRT),
        .LAT_MISC(LAT_MISC),
        .CNT_W   (CNT_W)
    ) u_lat (
        .funct5(bus.ex_funct5),
        .lat   (lat)
    );

    // The FP regfile is written at the edge that ends the completion cycle, so the
    // RAW check keeps stalling through that cycle instead of forwarding.
    assign pending      = state != IDLE;
    assign bus.wb_valid = (state == BUSY && cnt == '0) || state == HOLD;
    assign complete     = bus.wb_valid && bus.wb_ready;
    assign raw          = pending && fp_we_q &&
                          ((bus.ex_rs1_fp && bus.ex_rs1 == rd_q) ||
                           (bus.ex_rs2_fp && bus.ex_rs2 == rd_q));
    assign struct_hz    = bus.ex_fp_valid && pending && !complete;
    assign bus.stall    = !bus.flush && (raw || struct_hz);
    assign accept       = bus.ex_fp_valid && !bus.flush && !bus.stall;
    assign bus.wb_rd    = bus.wb_valid ? rd_q : 5'd0;
    assign bus.wb_fp_we = bus.wb_valid && fp_we_q;

    // Accept has priority: it can only fire while idle or on the completion edge,
    // which gives back-to-back issue without an IDLE bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rd_q          <= '0;
            fp_we_q       <= 1'b0;
            bus.fpu_start <= 1'b0;
            bus.fpu_sel   <= '0;
            bus.fpu_rm    <= '0;
        end else begin
            bus.fpu_start <= accept;
            if (accept) begin
                state       <= BUSY;
                cnt         <= lat - CNT_W'(1);
                rd_q        <= bus.ex_rd;
                fp_we_q     <= bus.ex_fp_we;
                bus.fpu_sel <= bus.ex_funct5;
                bus.fpu_rm  <= bus.ex_rm;
            end else if (complete) begin
                state <= IDLE;
            end else if (state == BUSY) begin
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
                else state <= HOLD;
            end
        end
    end

`ifdef FPU_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles <= '0;
        else if (bus.stall) stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed + randomized bench for fpu_issue_ctrl against a timestamp-based reference model.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] stall_cycles;

    fpu_issue_ctrl_if bus();

    fpu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: an op is outstanding from its accept cycle until the cycle its
    // result is taken; its result is visible from absolute cycle m_done on.
    bit          m_pend, m_we, m_start;
    int          m_done;
    logic [4:0]  m_rd, m_sel;
    logic [2:0]  m_rm;
    logic [31:0] m_scnt;
    bit          s_stall, s_valid, s_start;

    function automatic int lat_of(input logic [4:0] f);
        return (f == 5'b00000 || f == 5'b00001) ? 3 :
               (f == 5'b00010) ? 4 :
               (f == 5'b00011) ? 12 :
               (f == 5'b01011) ? 16 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [4:0] f, input logic [4:0] rd, input bit we,
                         input logic [4:0] rs1, input bit f1, input logic [4:0] rs2, input bit f2,
                         input bit fl, input bit rdy);
        bus.ex_fp_valid = v;
        bus.ex_funct5   = f;
        bus.ex_rm       = 3'($urandom);
        bus.ex_rd       = rd;
        bus.ex_fp_we    = we;
        bus.ex_rs1      = rs1;
        bus.ex_rs1_fp   = f1;
        bus.ex_rs2      = rs2;
        bus.ex_rs2_fp   = f2;
        bus.flush       = fl;
        bus.wb_ready    = rdy;
    endtask

    task automatic idle(input bit rdy);
        drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, rdy);
    endtask

    task automatic model_reset();
        m_pend  = 0;
        m_we    = 0;
        m_start = 0;
        m_done  = 0;
        m_rd    = '0;
        m_sel   = '0;
        m_rm    = '0;
        m_scnt  = '0;
    endtask

    // Called at a negedge with inputs already driven; checks, advances model, returns at next negedge.
    task automatic cycle();
        bit ev, hz, e_stall, e_acc;
        #1;
        ev = m_pend && cyc >= m_done;
        hz = m_pend && m_we && ((bus.ex_rs1_fp && bus.ex_rs1 == m_rd) ||
                                (bus.ex_rs2_fp && bus.ex_rs2 == m_rd));
        e_stall = !bus.flush && (hz || (bus.ex_fp_valid && m_pend && !(ev && bus.wb_ready)));
        e_acc   = bus.ex_fp_valid && !bus.flush && !e_stall;
        check("stall", bus.stall, e_stall);
        check("wb_valid", bus.wb_valid, ev);
        check("wb_rd", bus.wb_rd, ev ? m_rd : 5'd0);
        check("wb_fp_we", bus.wb_fp_we, ev && m_we);
        check("fpu_start", bus.fpu_start, m_start);
        check("fpu_sel", bus.fpu_sel, m_sel);
        check("fpu_rm", bus.fpu_rm, m_rm);
`ifdef FPU_STALL_CNT_EN
        check("stall_cycles", stall_cycles, m_scnt);
`else
        check("stall_cycles", stall_cycles, 32'd0);
`endif
        s_stall = bus.stall;
        s_valid = bus.wb_valid;
        s_start = bus.fpu_start;
        if (rst_n) begin
            m_scnt  = m_scnt + 32'(e_stall);
            m_start = e_acc;
            if (e_acc) begin
                m_pend = 1;
                m_done = cyc + lat_of(bus.ex_funct5);
                m_rd   = bus.ex_rd;
                m_we   = bus.ex_fp_we;
                m_sel  = bus.ex_funct5;
                m_rm   = bus.ex_rm;
            end else if (ev && bus.wb_ready) begin
                m_pend = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Cycles until the DUT raises wb_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n++;
            if (s_valid) break;
        end
    endtask

    initial begin
        int n;
        logic [31:0] sc0;
        logic [4:0] ops[6];
        model_reset();
        idle(1);
        @(negedge clk);
        cycle();
        check("rst_wb_valid", bus.wb_valid, 0);
        rst_n = 1'b1;
        cycle();

        // fadd rd=3: start next cycle, wb at t+3, idle at t+4
        drive(1, 5'b00000, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 1);
        cycle();
        idle(1);
        cycle();
        check("t1_start", s_start, 1);
        check("t1_sel", bus.fpu_sel, 5'b00000);
        n = 1;
        if (!s_valid) begin
            wait_valid(n);
            n++;
        end
        check("t1_lat", n, 3);
        check("t1_wb_rd", bus.wb_rd, 5'd0);
        cycle();
        check("t1_idle", s_valid, 0);

        // fdiv then fmul: 11 stall cycles, fmul accepted on fdiv completion, wb +4
        sc0 = stall_cycles;
        drive(1, 5'b00011, 5'd1, 1, 5'd0, 0, 5'd0, 0, 0, 1);
        cycle();
        drive(1, 5'b00010, 5'd2, 1, 5'd7, 0, 5'd8, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (!s_stall) break;
            n++;
        end
        check("t2_stall", n, 11);
        idle(1);
        wait_valid(n);
        check("t2_mul_lat", n, 4);
        cycle();
`ifdef FPU_STALL_CNT_EN
        check("t2_cnt", stall_cycles - sc0, 32'd11);
`else
        check("t2_cnt", stall_cycles - sc0, 32'd0);
`endif

        // RAW: fmul rd=5 then fadd reading f5 stalls through fmul completion
        drive(1, 5'b00010, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 1);
        cycle();
        drive(1, 5'b00000, 5'd6, 1, 5'd5, 1, 5'd0, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (!s_stall) break;
            n++;
        end
        check("t3_raw_stall", n, 4);
        idle(1);
        wait_valid(n);
        check("t3_add_lat", n, 3);
        cycle();

        // fsqrt held in HOLD for 3 not-ready cycles
        drive(1, 5'b01011, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 1);
        cycle();
        idle(0);
        wait_valid(n);
        check("t4_sqrt_lat", n, 16);
        cycle();
        cycle();
        check("t4_hold_rd", bus.wb_rd, 5'd9);
        idle(1);
        cycle();
        cycle();
        check("t4_idle", s_valid, 0);

        // flush blocks acceptance
        drive(1, 5'b00000, 5'd4, 1, 5'd0, 0, 5'd0, 0, 1, 1);
        cycle();
        check("t5_stall", s_stall, 0);
        idle(1);
        cycle();
        check("t5_start", s_start, 0);

        // async reset mid-fdiv
        drive(1, 5'b00011, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 1);
        cycle();
        drive(1, 5'b00000, 5'd8, 1, 5'd7, 1, 5'd0, 0, 0, 1);
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_sel", bus.fpu_sel, 5'd0);
        check("rst_rm", bus.fpu_rm, 3'd0);
        check("rst_start", bus.fpu_start, 0);
        check("rst_valid", bus.wb_valid, 0);
        check("rst_cnt", stall_cycles, 32'd0);
        model_reset();
        idle(1);
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        cycle();

        // randomized traffic with small register range to provoke RAW hazards
        for (int i = 0; i < 3000; i++) begin
            ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'($urandom)};
            drive($urandom_range(0, 1) == 1, ops[$urandom_range(0, 5)],
                  5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequential issue/writeback controller for the multi-cycle, non-pipelined FPU in the RV pipeline.
- Accepts one decoded FP operation at a time from the execute-stage decode signals (funct5, rm, rd).
- Drives a start/select handshake to the FPU, counts a per-class parametrised latency, and arbitrates writeback into the FP register file through a valid/ready port.
- Generates the pipeline stall for structural (FPU busy) and RAW (pending FP destination) hazards.

Parameters:
- LAT_ADD, 3, cycles for fadd/fsub (funct5 00000/00001)
- LAT_MUL, 4, cycles for fmul (00010)
- LAT_DIV, 12, cycles for fdiv (00011)
- LAT_SQRT, 16, cycles for fsqrt (01011)
- LAT_MISC, 1, cycles for every other funct5 (sgnj, min/max, cmp, cvt, mv)
- CNT_W, 5, latency counter width; must satisfy 2^CNT_W > max(LAT_*)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ex_fp_valid  in  1  FP operation presented this cycle
- ex_funct5  in  5  FP operation code
- ex_rm  in  3  rounding mode
- ex_rd  in  5  FP destination register
- ex_fp_we  in  1  op writes an FP register (0 for fcmp/fmv.x.w/fcvt.w.s)
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX
- ex_rs1_fp, ex_rs2_fp  in  1 each  source is an FP register (includes fsw data and fmv.x.w)
- flush  in  1  suppresses acceptance this cycle
- stall  out  1  hold IF/ID/EX
- fpu_start  out  1  one-cycle start pulse to the FPU
- fpu_sel  out  5  registered funct5, held for the whole operation
- fpu_rm  out  3  registered rm, held for the whole operation
- wb_valid  out  1  result ready for writeback
- wb_ready  in  1  writeback port free
- wb_rd  out  5  destination of completing op
- wb_fp_we  out  1  completing op writes FP regfile
- stall_cycles  out  32  stall performance counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state IDLE, counter 0, all outputs 0; any in-flight operation is abandoned.
- States:
  - IDLE: nothing in flight.
  - BUSY: counting down.
  - HOLD: result done, waiting for wb_ready.
- complete = wb_valid && wb_ready.
- Hazard rules:
  - raw = pending && ex_fp_we_q && ((ex_rs1_fp && ex_rs1==rd_q) || (ex_rs2_fp && ex_rs2==rd_q)).
  - pending = state != IDLE. The register is written at the clock edge, so raw also stalls during the completion cycle.
  - struct = ex_fp_valid && pending && !complete.
  - stall = !flush && (raw || struct). stall is combinational.
- Accept condition: ex_fp_valid && !flush && !stall.
  - Latches funct5, rm, rd, fp_we.
  - cnt <= LAT(class) − 1.
  - Next state is BUSY.
  - fpu_start = 1 in the following cycle only.
- BUSY:
  - wb_valid = (cnt == 0).
  - If cnt != 0, decrement.
  - If cnt == 0 and wb_ready, go to IDLE, or directly to BUSY if a new op is accepted in the same cycle (back-to-back).
  - If cnt == 0 and !wb_ready, go to HOLD.
- HOLD:
  - wb_valid = 1; wb_rd and wb_fp_we stay stable.
  - Leave on wb_ready, with the same next-state rule as BUSY.
- Latency: op accepted at cycle t gives wb_valid first at cycle t+LAT (LAT_MISC=1 → t+1).
- wb_valid, wb_rd and wb_fp_we are 0 in IDLE.
- flush only blocks acceptance in that cycle. An op already accepted is committed and always completes.
- Simultaneous completion and new accept: writeback of the old op and capture of the new op occur on the same edge. fpu_start pulses next cycle.

Optional Feature:
- Macro: FPU_STALL_CNT_EN.
- Defined: stall_cycles increments by 1 on every cycle with stall=1, wraps at 2^32 with no saturation, and resets to 0.
- Undefined: stall_cycles is tied to 0 and no counter flops are synthesised.

Decomposition:
- Package fpu_pkg holds:
  - funct5 localparams (FADD 00000, FSUB 00001, FMUL 00010, FDIV 00011, FSQRT 01011).
  - State encoding IDLE=2'd0, BUSY=2'd1, HOLD=2'd2.
  - Latency-class enum.
- One sub-module, fpu_lat_lookup: combinational funct5 → latency mapping using the LAT_* parameters.

Test Plan:
- Reset, then fadd rd=3 accepted at t → fpu_start at t+1, fpu_sel=00000, wb_valid=1 with wb_rd=3 exactly at t+3, IDLE at t+4.
- fdiv followed by fmul next cycle → stall=1 for 11 cycles; fmul accepted in fdiv's completion cycle; fmul wb at +4.
- fmul rd=5, then fadd reading rs1=5 (fp) → stall through the fmul completion cycle; accepted the cycle after.
- fsqrt completes with wb_ready=0 for 3 cycles → HOLD, wb_valid held with wb_rd stable; IDLE after the ready cycle.
- flush=1 with ex_fp_valid=1 → no accept, no fpu_start, stall=0; rst_n low mid-fdiv → all outputs 0 immediately.
- With FPU_STALL_CNT_EN, the fdiv/fmul sequence → stall_cycles=11; without the macro → stall_cycles stays 0.
